// File: rtl/lcd_pkg.sv
// Shared timing constants, colours and coordinate types for the 480x272 RGB565 LCD.
package lcd_pkg;

    localparam int unsigned COORD_W = 11;
    localparam int unsigned RGB_W   = 16;

    // Horizontal timing, in pixel clocks
    localparam int unsigned H_SYNC  = 41;
    localparam int unsigned H_BACK  = 2;
    localparam int unsigned H_DISP  = 480;
    localparam int unsigned H_FRONT = 2;
    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;

    // Vertical timing, in lines
    localparam int unsigned V_SYNC  = 10;
    localparam int unsigned V_BACK  = 2;
    localparam int unsigned V_DISP  = 272;
    localparam int unsigned V_FRONT = 2;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [RGB_W-1:0]   rgb_t;

    // RGB565 colours
    localparam rgb_t WHITE = 16'hFFFF;
    localparam rgb_t BLACK = 16'h0000;
    localparam rgb_t RED   = 16'hF800;
    localparam rgb_t GREEN = 16'h07E0;
    localparam rgb_t BLUE  = 16'h001F;

endpackage

// File: rtl/lcd_rgb_timing_if.sv
// Pixel pull bus between the timing generator (master) and the pixel source (slave).
interface lcd_rgb_timing_if;
    import lcd_pkg::*;

    coord_t pixel_xpos;
    coord_t pixel_ypos;
    rgb_t   pixel_data;

    modport master (
        output pixel_xpos,
        output pixel_ypos,
        input  pixel_data
    );

    modport slave (
        input  pixel_xpos,
        input  pixel_ypos,
        output pixel_data
    );

endinterface

// File: rtl/lcd_sync_cnt.sv
// Generic wrapping counter with registered sync level and active-window flag.
// Flags are computed from the next count so they line up with cnt on the same cycle.
module lcd_sync_cnt
    import lcd_pkg::*;
#(
    parameter int unsigned TOTAL   = H_TOTAL,
    parameter int unsigned SYNC    = H_SYNC,
    parameter int unsigned ACT_BEG = H_SYNC + H_BACK,
    parameter int unsigned ACT_END = H_SYNC + H_BACK + H_DISP - 1,
    parameter bit          SYNC_EN = 1'b1
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en,
    output coord_t cnt,
    output logic   sync,
    output logic   active,
    output logic   active_nxt_c,
    output logic   wrap_c
);

    coord_t cnt_nxt;

    // Next count: advance when enabled, wrap after TOTAL-1
    always_comb begin
        wrap_c  = en && (cnt == COORD_W'(TOTAL - 1));
        cnt_nxt = cnt;
        if (en) begin
            cnt_nxt = wrap_c ? '0 : cnt + COORD_W'(1);
        end
        active_nxt_c = (cnt_nxt >= COORD_W'(ACT_BEG)) && (cnt_nxt <= COORD_W'(ACT_END));
    end

    // Count, sync and window registers; sync is held high when sync output is disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            sync   <= !SYNC_EN;
            active <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            sync   <= SYNC_EN ? (cnt_nxt >= COORD_W'(SYNC)) : 1'b1;
            active <= active_nxt_c;
        end
    end

endmodule

// File: rtl/lcd_rgb_timing.sv
// RGB LCD timing generator and pixel-pull master.
// Requests each pixel one clock ahead of DE; the source returns registered pixel_data.
// LCD_SYNC_EN defined: HS/VS driven (HV + DE mode); undefined: HS/VS tied high (DE-only).
module lcd_rgb_timing
    import lcd_pkg::*;
#(
    parameter int unsigned CFG_H_SYNC  = H_SYNC,
    parameter int unsigned CFG_H_BACK  = H_BACK,
    parameter int unsigned CFG_H_DISP  = H_DISP,
    parameter int unsigned CFG_H_TOTAL = H_TOTAL,
    parameter int unsigned CFG_V_SYNC  = V_SYNC,
    parameter int unsigned CFG_V_BACK  = V_BACK,
    parameter int unsigned CFG_V_DISP  = V_DISP,
    parameter int unsigned CFG_V_TOTAL = V_TOTAL
) (
    input  logic             clk,
    input  logic             rst_n,
    lcd_rgb_timing_if.master pix,
    output logic             lcd_hs,
    output logic             lcd_vs,
    output logic             lcd_de,
    output rgb_t             lcd_rgb,
    output logic             lcd_bl,
    output logic             frame_start
);

`ifdef LCD_SYNC_EN
    localparam bit SYNC_EN = 1'b1;
`else
    localparam bit SYNC_EN = 1'b0;
`endif

    // Request window opens one clock before DE so registered source data meets DE
    localparam int unsigned H_REQ_BEG = CFG_H_SYNC + CFG_H_BACK - 1;
    localparam int unsigned H_REQ_END = CFG_H_SYNC + CFG_H_BACK + CFG_H_DISP - 2;
    localparam int unsigned V_ACT_BEG = CFG_V_SYNC + CFG_V_BACK;
    localparam int unsigned V_ACT_END = CFG_V_SYNC + CFG_V_BACK + CFG_V_DISP - 1;
    // xpos is loaded from the current count, one below the count it will sit beside
    localparam int unsigned X_OFS     = H_REQ_BEG - 2;
    localparam int unsigned Y_OFS     = V_ACT_BEG - 1;

    coord_t h_cnt;
    coord_t v_cnt;
    logic   h_req;
    logic   h_req_nxt;
    logic   h_wrap;
    logic   v_act;
    logic   v_act_nxt;
    logic   v_wrap;
    logic   req_nxt_c;

    lcd_sync_cnt #(
        .TOTAL   (CFG_H_TOTAL),
        .SYNC    (CFG_H_SYNC),
        .ACT_BEG (H_REQ_BEG),
        .ACT_END (H_REQ_END),
        .SYNC_EN (SYNC_EN)
    ) u_h_cnt (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (1'b1),
        .cnt          (h_cnt),
        .sync         (lcd_hs),
        .active       (h_req),
        .active_nxt_c (h_req_nxt),
        .wrap_c       (h_wrap)
    );

    lcd_sync_cnt #(
        .TOTAL   (CFG_V_TOTAL),
        .SYNC    (CFG_V_SYNC),
        .ACT_BEG (V_ACT_BEG),
        .ACT_END (V_ACT_END),
        .SYNC_EN (SYNC_EN)
    ) u_v_cnt (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (h_wrap),
        .cnt          (v_cnt),
        .sync         (lcd_vs),
        .active       (v_act),
        .active_nxt_c (v_act_nxt),
        .wrap_c       (v_wrap)
    );

    // Request window is never at a line wrap, so next v equals current v inside it
    assign req_nxt_c = h_req_nxt && v_act_nxt;

    // Pixel request, DE (request delayed one clock), frame pulse and sticky backlight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix.pixel_xpos <= '0;
            pix.pixel_ypos <= '0;
            lcd_de         <= 1'b0;
            frame_start    <= 1'b0;
            lcd_bl         <= 1'b0;
        end else begin
            pix.pixel_xpos <= req_nxt_c ? h_cnt - COORD_W'(X_OFS) : '0;
            pix.pixel_ypos <= req_nxt_c ? v_cnt - COORD_W'(Y_OFS) : '0;
            lcd_de         <= h_req && v_act;
            frame_start    <= v_wrap;
            lcd_bl         <= lcd_bl || v_wrap;
        end
    end

    // Blank RGB outside the data-enable window
    assign lcd_rgb = lcd_de ? pix.pixel_data : BLACK;

endmodule

// File: tb/tb_lcd_rgb_timing.sv
// Bench for lcd_rgb_timing: a default 480x272 instance and a scaled-down instance,
// both checked every cycle against a frame-position model derived from elapsed clocks.
module tb_lcd_rgb_timing;
    import lcd_pkg::*;

    localparam int unsigned S_HS = 4;
    localparam int unsigned S_HB = 2;
    localparam int unsigned S_HD = 16;
    localparam int unsigned S_HT = 24;
    localparam int unsigned S_VS = 2;
    localparam int unsigned S_VB = 2;
    localparam int unsigned S_VD = 6;
    localparam int unsigned S_VT = 12;
    localparam int unsigned S_FT = S_HT * S_VT;

`ifdef LCD_SYNC_EN
    localparam logic SYNC_ON = 1'b1;
`else
    localparam logic SYNC_ON = 1'b0;
`endif

    typedef struct packed {
        logic   hs;
        logic   vs;
        logic   de;
        logic   fs;
        logic   bl;
        coord_t x;
        coord_t y;
        rgb_t   rgb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned t;
    int          checks = 0;
    int          errors = 0;
    rgb_t        salt;

    logic d_hs, d_vs, d_de, d_bl, d_fs;
    logic s_hs, s_vs, s_de, s_bl, s_fs;
    rgb_t d_rgb, s_rgb;

    lcd_rgb_timing_if d_if ();
    lcd_rgb_timing_if s_if ();

    always #5 clk = ~clk;

    lcd_rgb_timing u_dut_d (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix         (d_if),
        .lcd_hs      (d_hs),
        .lcd_vs      (d_vs),
        .lcd_de      (d_de),
        .lcd_rgb     (d_rgb),
        .lcd_bl      (d_bl),
        .frame_start (d_fs)
    );

    lcd_rgb_timing #(
        .CFG_H_SYNC  (S_HS),
        .CFG_H_BACK  (S_HB),
        .CFG_H_DISP  (S_HD),
        .CFG_H_TOTAL (S_HT),
        .CFG_V_SYNC  (S_VS),
        .CFG_V_BACK  (S_VB),
        .CFG_V_DISP  (S_VD),
        .CFG_V_TOTAL (S_VT)
    ) u_dut_s (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix         (s_if),
        .lcd_hs      (s_hs),
        .lcd_vs      (s_vs),
        .lcd_de      (s_de),
        .lcd_rgb     (s_rgb),
        .lcd_bl      (s_bl),
        .frame_start (s_fs)
    );

    function automatic rgb_t pix_f(input int unsigned x, input int unsigned y);
        logic [10:0] xx;
        logic [10:0] yy;
        xx = 11'(x);
        yy = 11'(y);
        return {xx[4:0], yy[5:0], xx[4:0]} ^ salt;
    endfunction

    // Source: valid coordinates map to the pattern, anything else returns junk
    function automatic rgb_t src(input coord_t x, input coord_t y);
        if (x == '0 || y == '0)
            return ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'($urandom);
        return pix_f(int'(x), int'(y));
    endfunction

    always @(posedge clk) begin
        d_if.pixel_data <= src(d_if.pixel_xpos, d_if.pixel_ypos);
        s_if.pixel_data <= src(s_if.pixel_xpos, s_if.pixel_ypos);
    end

    // Clocks elapsed since reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) t <= 0;
        else        t <= t + 1;
    end

    // Expected pins at a given elapsed-clock count for one timing configuration
    function automatic exp_t model(input int unsigned tc,
                                   input int unsigned hs, input int unsigned hb,
                                   input int unsigned hd, input int unsigned ht,
                                   input int unsigned vs, input int unsigned vb,
                                   input int unsigned vd, input int unsigned vt);
        exp_t        e;
        int unsigned h, v;
        logic        vact, req;
        h    = tc % ht;
        v    = (tc / ht) % vt;
        vact = (v >= vs + vb) && (v < vs + vb + vd);
        req  = vact && (h >= hs + hb - 1) && (h < hs + hb + hd - 1);
        e.hs  = SYNC_ON ? (h >= hs) : 1'b1;
        e.vs  = SYNC_ON ? (v >= vs) : 1'b1;
        e.de  = vact && (h >= hs + hb) && (h < hs + hb + hd);
        e.x   = req ? 11'(h - (hs + hb - 2)) : 11'd0;
        e.y   = req ? 11'(v - (vs + vb - 1)) : 11'd0;
        e.rgb = e.de ? pix_f(h - (hs + hb) + 1, v - (vs + vb) + 1) : 16'h0000;
        e.fs  = (tc > 0) && (h == 0) && (v == 0);
        e.bl  = tc >= ht * vt;
        return e;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got %h expected %h", name, t, act, exp);
        end
    endtask

    task automatic check_pins(input string tag, input exp_t e,
                              input logic hs, input logic vs, input logic de,
                              input logic fs, input logic bl,
                              input coord_t x, input coord_t y, input rgb_t rgb);
        chk({tag, "_hs"},   16'(hs),  16'(e.hs));
        chk({tag, "_vs"},   16'(vs),  16'(e.vs));
        chk({tag, "_de"},   16'(de),  16'(e.de));
        chk({tag, "_fs"},   16'(fs),  16'(e.fs));
        chk({tag, "_bl"},   16'(bl),  16'(e.bl));
        chk({tag, "_xpos"}, 16'(x),   16'(e.x));
        chk({tag, "_ypos"}, 16'(y),   16'(e.y));
        chk({tag, "_rgb"},  rgb,      e.rgb);
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        check_pins("d", model(t, H_SYNC, H_BACK, H_DISP, H_TOTAL, V_SYNC, V_BACK, V_DISP, V_TOTAL),
                   d_hs, d_vs, d_de, d_fs, d_bl, d_if.pixel_xpos, d_if.pixel_ypos, d_rgb);
        check_pins("s", model(t, S_HS, S_HB, S_HD, S_HT, S_VS, S_VB, S_VD, S_VT),
                   s_hs, s_vs, s_de, s_fs, s_bl, s_if.pixel_xpos, s_if.pixel_ypos, s_rgb);
    end

    task automatic check_all_reset(input string tag);
        chk({tag, "_d_hs"}, 16'(d_hs), 16'(!SYNC_ON));
        chk({tag, "_d_vs"}, 16'(d_vs), 16'(!SYNC_ON));
        chk({tag, "_d_de"}, 16'(d_de), 16'h0);
        chk({tag, "_d_rgb"}, d_rgb, 16'h0);
        chk({tag, "_d_bl"}, 16'(d_bl), 16'h0);
        chk({tag, "_d_fs"}, 16'(d_fs), 16'h0);
        chk({tag, "_d_x"}, 16'(d_if.pixel_xpos), 16'h0);
        chk({tag, "_s_hs"}, 16'(s_hs), 16'(!SYNC_ON));
        chk({tag, "_s_de"}, 16'(s_de), 16'h0);
        chk({tag, "_s_rgb"}, s_rgb, 16'h0);
        chk({tag, "_s_bl"}, 16'(s_bl), 16'h0);
        chk({tag, "_s_x"}, 16'(s_if.pixel_xpos), 16'h0);
        chk({tag, "_s_y"}, 16'(s_if.pixel_ypos), 16'h0);
    endtask

    initial begin
        int n;
        int de_line;
        int de_frame;
        int hs_low;
        salt     = 16'($urandom);
        de_line  = 0;
        de_frame = 0;
        hs_low   = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_reset("rst");

        @(posedge clk);
        #2 rst_n = 1'b1;

        // Run the scaled instance past several frames, then reset at a random point
        n = int'(S_FT) * 3 + int'($urandom_range(1, S_FT - 1));
        repeat (n) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_reset("async_rst");
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 7000; i++) begin
            @(negedge clk);
            if (t >= 12 * 525 && t < 13 * 525 && d_de) de_line++;
            if (t >= S_FT && t < 2 * S_FT && s_de) de_frame++;
            if (t >= 5 * S_HT && t < 6 * S_HT && !s_hs) hs_low++;
            case (t)
                40:   chk("lit_hs_low",  16'(d_hs), 16'(!SYNC_ON));
                41:   chk("lit_hs_high", 16'(d_hs), 16'h1);
                5249: chk("lit_vs_low",  16'(d_vs), 16'(!SYNC_ON));
                5250: chk("lit_vs_high", 16'(d_vs), 16'h1);
                287: begin
                    chk("lit_s_fs_pre", 16'(s_fs), 16'h0);
                    chk("lit_s_bl_pre", 16'(s_bl), 16'h0);
                end
                288: begin
                    chk("lit_s_fs", 16'(s_fs), 16'h1);
                    chk("lit_s_bl", 16'(s_bl), 16'h1);
                end
                6299: chk("lit_de_before", 16'(d_de), 16'h0);
                6342: begin
                    chk("lit_x_first", 16'(d_if.pixel_xpos), 16'd1);
                    chk("lit_y_first", 16'(d_if.pixel_ypos), 16'd1);
                end
                6343: begin
                    chk("lit_de_first",  16'(d_de), 16'h1);
                    chk("lit_rgb_first", d_rgb, 16'h0821 ^ salt);
                end
                6821: chk("lit_x_last", 16'(d_if.pixel_xpos), 16'd480);
                6822: begin
                    chk("lit_de_last",  16'(d_de), 16'h1);
                    chk("lit_rgb_last", d_rgb, 16'h0020 ^ salt);
                end
                6823: begin
                    chk("lit_de_after",  16'(d_de), 16'h0);
                    chk("lit_rgb_after", d_rgb, 16'h0);
                    chk("lit_bl_still_off", 16'(d_bl), 16'h0);
                end
                default: ;
            endcase
        end

        chk("de_per_line",     16'(de_line),  16'd480);
        chk("de_per_frame_s",  16'(de_frame), 16'd96);
        chk("hs_low_per_line", 16'(hs_low),   SYNC_ON ? 16'd4 : 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_rgb_timing.md
# lcd_rgb_timing

Timing generator and pixel-pull master for the 480x272 RGB565 parallel LCD. It free-runs horizontal/vertical counters and requests each pixel one clock early by driving `pixel_xpos`/`pixel_ypos` to the pattern/display source, which returns registered `pixel_data`. It drives HS/VS/DE/RGB/backlight to the panel pins and sits between the pixel source and the top-level LCD pads.

## Interface
- `H_SYNC`, 41, HS low width (clocks)
- `H_BACK`, 2, horizontal back porch
- `H_DISP`, 480, active pixels per line
- `H_TOTAL`, 525, clocks per line (= sync+back+disp+front 2)
- `V_SYNC`, 10, VS low width (lines)
- `V_BACK`, 2, vertical back porch
- `V_DISP`, 272, active lines
- `V_TOTAL`, 286, lines per frame (front 2)
- `clk`  in  1  pixel clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `pixel_data`  in  16  RGB565 from source, one cycle after request
- `pixel_xpos`  out  11  requested column, 1..H_DISP; 0 outside request window
- `pixel_ypos`  out  11  requested row, 1..V_DISP; 0 outside request window
- `lcd_hs`  out  1  horizontal sync, active low
- `lcd_vs`  out  1  vertical sync, active low
- `lcd_de`  out  1  data enable
- `lcd_rgb`  out  16  panel RGB565; 0 when `lcd_de` low
- `lcd_bl`  out  1  backlight enable
- `frame_start`  out  1  one-clock pulse at start of each frame

## Operation
- `h_cnt` runs 0..H_TOTAL-1, then wraps to 0. `v_cnt` increments on each h wrap and runs 0..V_TOTAL-1, wrapping together with `h_cnt`.
- `lcd_hs` = (`h_cnt` >= H_SYNC). `lcd_vs` = (`v_cnt` >= V_SYNC).
- Vertical active window: `v_cnt` in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_DISP-1] = [12, 283].
- `data_req` (internal) is high when the vertical window is active and `h_cnt` is in [H_SYNC+H_BACK-1, H_SYNC+H_BACK+H_DISP-2] = [42, 521].
- `pixel_xpos` = `h_cnt` − 41 when `data_req` is high, giving 1..480; otherwise 0.
- `pixel_ypos` = `v_cnt` − 11 when `data_req` is high, giving 1..272; otherwise 0.
- `lcd_de` is high when the vertical window is active and `h_cnt` is in [43, 522], i.e. `data_req` delayed by one clock.
- `lcd_rgb` = `lcd_de` ? `pixel_data` : 16'h0000.
- `frame_start` is a registered pulse, high exactly while `h_cnt`=0 and `v_cnt`=0 following a wrap. It is not asserted on the first cycle out of reset.
- `lcd_bl` is a registered flag: 0 from reset, set at the first `frame_start`, then sticky until reset. This hides the first, possibly garbage frame.
- Counter arithmetic uses 11-bit unsigned values. Subtractions are evaluated only inside the request window, so they never underflow into the outputs.

## Timing
- Reset values: `h_cnt`=0, `v_cnt`=0, `frame_start`=0, `lcd_bl`=0. As a consequence `lcd_hs`=0, `lcd_vs`=0, `lcd_de`=0, `lcd_rgb`=0, `pixel_xpos`=0, `pixel_ypos`=0.
- Request-to-data latency is exactly 1 clock. The source must register `pixel_data` on the clock that samples xpos/ypos.
- Line period is 525 clocks; frame period is 525×286 = 150150 clocks.
- Reset asserted mid-frame forces all outputs to their reset values immediately (asynchronously). The frame restarts at `h_cnt`=0, `v_cnt`=0, and `lcd_bl` stays 0 until the next full frame completes.
- Simultaneous h and v wrap (525th clock of line 285) yields `h_cnt`=0, `v_cnt`=0 and `frame_start`=1 on the next clock.

## Configuration
- Macro: `LCD_SYNC_EN`.
- Defined: `lcd_hs` and `lcd_vs` are driven as described above (HV + DE mode).
- Undefined: `lcd_hs` and `lcd_vs` are tied to 1 (DE-only panel mode). The counters, DE, RGB, `frame_start` and backlight behaviour are unchanged.

## Structure
- Shared package `lcd_pkg`:
  - default 480x272 timing constants (H_/V_ SYNC, BACK, DISP, TOTAL);
  - RGB565 colour constants (WHITE, BLACK, RED, GREEN, BLUE);
  - the 11-bit coordinate width.
- Natural sub-module: `lcd_sync_cnt`, a generic counter/sync/window generator instantiated once for horizontal and once for vertical. It outputs the count, the sync level, the active flag and the wrap pulse.

## Test plan
- Release reset, run 2 frames → `lcd_hs` low for 41 clocks every 525; `lcd_vs` low for 10 lines every 286; `frame_start` pulses every 150150 clocks.
- Drive `pixel_data` = {xpos[4:0], ypos[5:0], xpos[4:0]} registered one cycle → in line `v_cnt`=12, first DE clock (`h_cnt`=43) carries the value for xpos=1,ypos=1; last DE clock (`h_cnt`=522) carries xpos=480.
- Check `lcd_de` high count = 480 per active line and 480×272 = 130560 per frame; `lcd_rgb`=0 whenever `lcd_de`=0, even with `pixel_data`=16'hFFFF.
- `lcd_bl`: 0 through the entire first frame after reset, 1 from the first `frame_start` onward.
- Assert `rst_n`=0 at `h_cnt`=300, `v_cnt`=150 → all outputs 0 in the same cycle; after release, `h_cnt` restarts at 0 and `lcd_bl` returns to 1 only after 150150 clocks.
- Build without `LCD_SYNC_EN` → `lcd_hs`=`lcd_vs`=1 constantly; DE/RGB sequence identical to the defined build.
